imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, instruction-memory address width; instruction word width is fixed at 19.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  begin a load session.
REQ-006 byte_in  input  8  serial payload byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  ADDR_WIDTH  instruction-memory write address.
REQ-011 wr_data  output  19  instruction word to write.
REQ-012 core_rst  output  1  holds the processor datapath in reset while high.
REQ-013 busy  output  1  session in progress.
REQ-014 done  output  1  session completed successfully (level).
REQ-015 error  output  1  session aborted on a format fault (level).

Function
REQ-016 A byte transfers only on a cycle with byte_valid and byte_ready both high; byte_in is ignored otherwise.
REQ-017 States: IDLE, LEN_LO, LEN_HI, B0, B1, B2, CHK (only with CHECKSUM_EN), DONE, ERR.
REQ-018 byte_ready is high in LEN_LO, LEN_HI, B0, B1, B2, CHK and low in IDLE, DONE, ERR; it is a registered output.
REQ-019 start in IDLE, DONE or ERR -> LEN_LO, clears wr_addr, done, error, word counter and checksum; start in any other state is ignored.
REQ-020 LEN_LO captures count[7:0]; LEN_HI captures count[15:8].
REQ-021 After LEN_HI: count > 2**ADDR_WIDTH -> ERR; count == 0 -> CHK (with CHECKSUM_EN) or DONE; else -> B0.
REQ-022 B0 captures word[7:0], B1 captures word[15:8], B2 captures word[18:16] from byte_in[2:0].
REQ-023 byte_in[7:3] nonzero in B2 -> ERR, no write for that word.
REQ-024 On a valid B2 transfer, the next cycle has wr_en=1 with wr_data=assembled word and wr_addr=current word index; wr_en is high for exactly one cycle.
REQ-025 wr_addr increments by one the cycle after each write; the last word of a 2**ADDR_WIDTH-word image writes address 2**ADDR_WIDTH-1 and wr_addr then wraps to 0.
REQ-026 After B2 the state returns to B0 until count words have been accepted, then goes to CHK or DONE.
REQ-027 busy is high in LEN_LO through CHK, low otherwise.
REQ-028 core_rst is high in every state except DONE; it drops the cycle DONE is entered and rises again on the next start.
REQ-029 done is high only in DONE; error is high only in ERR; both hold until start or rst.
REQ-030 byte_valid held low stalls any state indefinitely with no timeout.

Reset
REQ-031 rst has priority over start and all transfers; an active session is abandoned and no further wr_en is issued.
REQ-032 Reset values: state IDLE, byte_ready 0, wr_en 0, wr_addr 0, wr_data 0, core_rst 1, busy 0, done 0, error 0, counters and checksum 0.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN defined: running XOR of all accepted bytes from LEN_LO through the last B2; CHK accepts one byte; equal to running XOR -> DONE, else -> ERR (words already written remain written).
REQ-034 Macro IMEM_LOADER_CHECKSUM_EN undefined: CHK state and checksum logic absent; the last B2 (or LEN_HI when count == 0) goes directly to DONE.

Verification
REQ-035 Reset then start, bytes 02 00 | 34 12 01 | FF FF 07 -> writes (0,0x11234) and (1,0x7FFFF), one cycle wr_en each, then done=1, core_rst=0.
REQ-036 Same stream with byte_valid toggled every other cycle -> identical writes and final state; no byte double-counted.
REQ-037 Bytes 01 00 | 00 00 08 -> ERR, error=1, no wr_en, core_rst=1, byte_ready=0.
REQ-038 Bytes 01 10 (count 0x1001 > 4096 with ADDR_WIDTH=12) -> ERR after LEN_HI, no writes.
REQ-039 With IMEM_LOADER_CHECKSUM_EN, bytes 01 00 AA 55 03 then checksum 0xFD -> done=1; checksum 0x00 -> error=1 after one write to address 0.
REQ-040 rst asserted after B1 of a 3-word load -> all outputs at reset values next cycle; new start and full stream loads correctly from address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte stream, instruction-memory write port and session
// status of the instruction-memory loader.
//   start       : begin a load session
//   byte_in     : serial payload byte, qualified by byte_valid
//   byte_valid  : byte_in carries data this cycle
//   byte_ready  : loader accepts byte_in this cycle
//   wr_en       : one-cycle instruction-memory write strobe
//   wr_addr     : instruction-memory write address
//   wr_data     : 19-bit instruction word
//   core_rst    : holds the processor datapath in reset while high
//   busy        : session in progress
//   done        : session completed successfully (level)
//   error       : session aborted on a format fault (level)
// master drives the byte stream, slave is the loader.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [18:0]           wr_data;
    logic                  core_rst;
    logic                  busy;
    logic                  done;
    logic                  error;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, core_rst, busy, done, error
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, core_rst, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader -- receives an instruction image over a byte stream and writes
// it into instruction memory while holding the core in reset.
// Stream format: count lo, count hi, then per word 3 bytes (bits 7:0, 15:8,
// 18:16 in byte[2:0] with byte[7:3] required zero), then an optional
// checksum byte.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : imem_loader_if.slave (byte stream in, memory write port and
//          status out; all outputs registered)
// Build option: define IMEM_LOADER_CHECKSUM_EN to add the CHK state, which
// compares one trailing byte against the XOR of every accepted byte.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    localparam int unsigned WORD_W = 19;
    localparam int unsigned LEN_W  = 16;
    // Wide enough to hold both a 16-bit count and 2**ADDR_WIDTH.
    localparam int unsigned CNT_W  = (ADDR_WIDTH + 1 > LEN_W + 1) ? ADDR_WIDTH + 1 : LEN_W + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_WIDTH;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_B0,
        S_B1,
        S_B2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State reached once the payload is complete.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CHK;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t state_q, state_d;

    logic [LEN_W-1:0]      count_q;
    logic [CNT_W-1:0]      words_q;
    logic [15:0]           word_lo_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic                  byte_ready_q;
    logic                  busy_q;
    logic                  core_rst_q;
    logic                  done_q;
    logic                  error_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [WORD_W-1:0]     wr_data_q;

    logic                  xfer_c;
    logic                  start_c;
    logic                  write_c;
    logic [LEN_W-1:0]      len_c;
    logic                  active_d;

    assign xfer_c  = bus.byte_valid && byte_ready_q;
    assign start_c = bus.start &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and write request.
    always_comb begin
        state_d = state_q;
        write_c = 1'b0;
        len_c   = {bus.byte_in, count_q[7:0]};

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer_c) begin
                    state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (xfer_c) begin
                    if (CNT_W'(len_c) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (len_c == '0) begin
                        state_d = S_FINAL;
                    end else begin
                        state_d = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer_c) begin
                    state_d = S_B1;
                end
            end
            S_B1: begin
                if (xfer_c) begin
                    state_d = S_B2;
                end
            end
            S_B2: begin
                if (xfer_c) begin
                    if (bus.byte_in[7:3] != 5'd0) begin
                        state_d = S_ERR;
                    end else begin
                        write_c = 1'b1;
                        if (words_q + CNT_W'(1) == CNT_W'(count_q)) begin
                            state_d = S_FINAL;
                        end else begin
                            state_d = S_B0;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer_c) begin
                    state_d = (bus.byte_in == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign active_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERR);

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            words_q      <= '0;
            word_lo_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            byte_ready_q <= active_d;
            busy_q       <= active_d;
            core_rst_q   <= (state_d != S_DONE);
            done_q       <= (state_d == S_DONE);
            error_q      <= (state_d == S_ERR);
            wr_en_q      <= write_c;

            if (write_c) begin
                wr_data_q <= {bus.byte_in[2:0], word_lo_q};
            end

            if (start_c) begin
                wr_addr_q <= '0;
                words_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_q    <= '0;
`endif
            end else begin
                // Address advances the cycle after each write strobe.
                if (wr_en_q) begin
                    wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                end
                if (write_c) begin
                    words_q <= words_q + CNT_W'(1);
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer_c && (state_q == S_LEN_LO || state_q == S_LEN_HI ||
                               state_q == S_B0 || state_q == S_B1 || state_q == S_B2)) begin
                    csum_q <= csum_q ^ bus.byte_in;
                end
`endif
            end

            if (xfer_c) begin
                case (state_q)
                    S_LEN_LO: count_q[7:0]    <= bus.byte_in;
                    S_LEN_HI: count_q[15:8]   <= bus.byte_in;
                    S_B0:     word_lo_q[7:0]  <= bus.byte_in;
                    S_B1:     word_lo_q[15:8] <= bus.byte_in;
                    default:  ;
                endcase
            end
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.busy       = busy_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- randomized bench for imem_loader with a stream-level
// reference model (parses the byte stream into expected writes and outcome).
module tb_imem_loader;

    localparam int unsigned AW = 12;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus();

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  stream[$];
    logic [31:0] exp_wr[$];
    logic [31:0] got_wr[$];
    bit          exp_done;
    bit          exp_err;
    int          n_use;
    int          valid_mode;
    bit          toggle;
    logic        prev_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every strobe and requires single-cycle pulses.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            check("wr_en_single", 32'(prev_wr), 32'd0);
            got_wr.push_back({1'b0, bus.wr_addr, bus.wr_data});
        end
        prev_wr = bus.wr_en;
    end

    // Reference model: parse the stream into writes, outcome and bytes used.
    task automatic run_model();
        int         cnt;
        int         pos;
        logic [7:0] x;
        logic [7:0] b0, b1, b2;
        exp_wr.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        cnt = int'({stream[1], stream[0]});
        x   = stream[0] ^ stream[1];
        pos = 2;
        if (cnt > (1 << AW)) begin
            exp_err = 1'b1;
            n_use   = 2;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            b0 = stream[pos];
            b1 = stream[pos + 1];
            b2 = stream[pos + 2];
            pos += 3;
            x = x ^ b0 ^ b1 ^ b2;
            if (b2 > 8'd7) begin
                exp_err = 1'b1;
                n_use   = pos;
                return;
            end
            exp_wr.push_back({1'b0, AW'(w % (1 << AW)), b2[2:0], b1, b0});
        end
        if (CSUM) begin
            n_use    = pos + 1;
            exp_done = (stream[pos] == x);
            exp_err  = !exp_done;
        end else begin
            n_use    = pos;
            exp_done = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent = 1'b0;
        for (int t = 0; t < 1000 && !sent; t++) begin
            @(negedge clk);
            case (valid_mode)
                0:       bus.byte_valid = 1'b1;
                1:       begin toggle = !toggle; bus.byte_valid = toggle; end
                default: bus.byte_valid = ($urandom_range(99) < 60);
            endcase
            bus.byte_in = bus.byte_valid ? b : 8'($urandom);
            // Start mid-session must be ignored.
            bus.start   = (valid_mode == 2) && ($urandom_range(99) < 5);
            sent = bus.byte_valid && bus.byte_ready;
            @(posedge clk);
        end
        if (!sent) check("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start      = 1'b0;
        check("start_busy",     32'(bus.busy),     32'd1);
        check("start_core_rst", 32'(bus.core_rst), 32'd1);
        check("start_done",     32'(bus.done),     32'd0);
        check("start_error",    32'(bus.error),    32'd0);
        check("start_wr_addr",  32'(bus.wr_addr),  32'd0);
    endtask

    task automatic run_session(input int mode, input int stall);
        run_model();
        got_wr.delete();
        valid_mode = mode;
        toggle     = 1'b0;
        do_start();
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            bus.byte_valid = 1'b0;
            bus.byte_in    = 8'($urandom);
        end
        if (stall > 0) begin
            check("stall_busy",  32'(bus.busy),       32'd1);
            check("stall_ready", 32'(bus.byte_ready), 32'd1);
        end
        for (int i = 0; i < n_use; i++) send_byte(stream[i]);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        repeat (2) @(negedge clk);
        check("n_writes", 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check("wr_word", got_wr[i], exp_wr[i]);
        check("done",       32'(bus.done),       32'(exp_done));
        check("error",      32'(bus.error),      32'(exp_err));
        check("core_rst",   32'(bus.core_rst),   32'(!exp_done));
        check("byte_ready", 32'(bus.byte_ready), 32'd0);
        check("busy",       32'(bus.busy),       32'd0);
        check("wr_addr_end", 32'(bus.wr_addr),   32'(exp_wr.size() % (1 << AW)));
    endtask

    task automatic gen_random();
        int         cnt;
        logic [7:0] x;
        logic [7:0] b;
        stream.delete();
        cnt = ($urandom_range(9) == 0) ? int'($urandom_range(4097, 65535))
                                       : int'($urandom_range(0, 6));
        stream.push_back(8'(cnt));
        stream.push_back(8'(cnt >> 8));
        x = stream[0] ^ stream[1];
        if (cnt <= 6) begin
            for (int w = 0; w < cnt; w++) begin
                for (int k = 0; k < 3; k++) begin
                    if (k < 2)
                        b = 8'($urandom);
                    else if ($urandom_range(9) == 0)
                        b = 8'($urandom_range(8, 255));
                    else
                        b = 8'($urandom_range(0, 7));
                    stream.push_back(b);
                    x = x ^ b;
                end
            end
        end
        stream.push_back(($urandom_range(9) < 7) ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] x;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("rst_wr_addr",    32'(bus.wr_addr),    32'd0);
        check("rst_wr_data",    32'(bus.wr_data),    32'd0);
        check("rst_core_rst",   32'(bus.core_rst),   32'd1);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_error",      32'(bus.error),      32'd0);
        rst = 1'b0;

        // Two-word load (trailing byte is the correct checksum 0x22).
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h22};
        run_session(0, 30);
        check("basic_w0", (got_wr.size() > 0) ? got_wr[0] : 32'hFFFFFFFF, {1'b0, 12'h000, 19'h11234});
        check("basic_w1", (got_wr.size() > 1) ? got_wr[1] : 32'hFFFFFFFF, {1'b0, 12'h001, 19'h7FFFF});

        // Same stream with byte_valid toggling.
        run_session(1, 0);
        check("toggle_w1", (got_wr.size() > 1) ? got_wr[1] : 32'hFFFFFFFF, {1'b0, 12'h001, 19'h7FFFF});

        // Bad high bits in B2.
        stream = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00};
        run_session(0, 0);
        check("badb2_error", 32'(bus.error), 32'd1);

        // Count 0x1001 exceeds the memory.
        stream = '{8'h01, 8'h10, 8'h00};
        run_session(2, 0);
        check("toolong_error", 32'(bus.error), 32'd1);

        // Zero-length image.
        stream = '{8'h00, 8'h00, 8'h00};
        run_session(0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        stream = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'h03, 8'hFD};
        run_session(0, 0);
        check("csum_ok_done", 32'(bus.done), 32'd1);
        stream = '{8'h01, 8'h00, 8'hAA, 8'h55, 8'h03, 8'h00};
        run_session(0, 0);
        check("csum_bad_error", 32'(bus.error), 32'd1);
        check("csum_bad_write", (got_wr.size() > 0) ? got_wr[0] : 32'hFFFFFFFF, {1'b0, 12'h000, 19'h355AA});
`endif

        // Reset in the middle of a 3-word load, after B1 of the second word.
        got_wr.delete();
        valid_mode = 0;
        do_start();
        stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h03, 8'h44, 8'h55};
        for (int i = 0; i < 7; i++) send_byte(stream[i]);
        @(negedge clk);
        rst            = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h06;
        @(negedge clk);
        check("mid_rst_byte_ready", 32'(bus.byte_ready), 32'd0);
        check("mid_rst_wr_en",      32'(bus.wr_en),      32'd0);
        check("mid_rst_wr_addr",    32'(bus.wr_addr),    32'd0);
        check("mid_rst_wr_data",    32'(bus.wr_data),    32'd0);
        check("mid_rst_core_rst",   32'(bus.core_rst),   32'd1);
        check("mid_rst_busy",       32'(bus.busy),       32'd0);
        check("mid_rst_done",       32'(bus.done),       32'd0);
        check("mid_rst_error",      32'(bus.error),      32'd0);
        rst            = 1'b0;
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_writes", 32'(got_wr.size()), 32'd1);
        stream = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h01, 8'hFF, 8'hFF, 8'h07, 8'h22};
        run_session(0, 0);

        // Full 2**AW-word image: last address then wrap to 0.
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h10);
        x = 8'h10;
        for (int w = 0; w < (1 << AW); w++) begin
            for (int k = 0; k < 3; k++) begin
                stream.push_back((k < 2) ? 8'($urandom) : 8'($urandom_range(0, 7)));
                x = x ^ stream[stream.size() - 1];
            end
        end
        stream.push_back(x);
        run_session(0, 0);
        check("full_last_addr", (got_wr.size() > 0) ? 32'(got_wr[got_wr.size() - 1] >> 19) : 32'hFFFFFFFF,
              32'((1 << AW) - 1));

        // Randomized sessions.
        for (int r = 0; r < 30; r++) begin
            gen_random();
            run_session(2, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
